// File: rtl/tetris_pkg.sv
// Shared board geometry, cell type, colour codes and engine state encoding for the
// board memory arbiter and its clients.
package tetris_pkg;

    localparam int unsigned BOARD_COLS = 10;
    localparam int unsigned BOARD_ROWS = 20;
    localparam int unsigned CELL_W     = 3;
    localparam int unsigned ADDR_W     = 8;

    typedef logic [CELL_W-1:0] cell_t;

    localparam cell_t CellEmpty = 3'd0;
    localparam cell_t CellI     = 3'd1;
    localparam cell_t CellO     = 3'd2;
    localparam cell_t CellT     = 3'd3;
    localparam cell_t CellS     = 3'd4;
    localparam cell_t CellZ     = 3'd5;
    localparam cell_t CellJ     = 3'd6;
    localparam cell_t CellL     = 3'd7;

    typedef logic [2:0] eng_state_t;

    localparam eng_state_t StIdle     = 3'd0;
    localparam eng_state_t StClear    = 3'd1;
    localparam eng_state_t StShiftRd  = 3'd2;
    localparam eng_state_t StShiftWr  = 3'd3;
    localparam eng_state_t StShiftTop = 3'd4;
    localparam eng_state_t StDone     = 3'd5;

    function automatic int unsigned cell_addr(input int unsigned row, input int unsigned col,
                                              input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/board_mem_arbiter_if.sv
// Board memory access bus: video read port plus game-logic read/write port.
// master = requesters (renderer, game logic), slave = board_mem_arbiter.
interface board_mem_arbiter_if
    import tetris_pkg::*;
#(
    parameter int unsigned AW = ADDR_W,
    parameter int unsigned CW = CELL_W
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [CW-1:0] vid_rdata;

    logic          gl_req;
    logic          gl_we;
    logic [AW-1:0] gl_addr;
    logic [CW-1:0] gl_wdata;
    logic          gl_gnt;
    logic          gl_rvalid;
    logic [CW-1:0] gl_rdata;

    modport master (
        output vid_req, vid_addr, gl_req, gl_we, gl_addr, gl_wdata,
        input  vid_rdata, gl_gnt, gl_rvalid, gl_rdata
    );

    modport slave (
        input  vid_req, vid_addr, gl_req, gl_we, gl_addr, gl_wdata,
        output vid_rdata, gl_gnt, gl_rvalid, gl_rdata
    );
endinterface

// File: rtl/board_ram.sv
// Single-port board storage with registered read; no reset so it maps onto block or
// distributed RAM.
module board_ram #(
    parameter int unsigned Depth = 200,
    parameter int unsigned AW    = 8,
    parameter int unsigned CW    = 3
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [CW-1:0] wdata_i,
    output logic [CW-1:0] rdata_o
);

    logic [CW-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Shares the single board RAM port: video > maintenance engine > game logic.
// Define BOARD_ARB_SHIFT_EN to build the row-shift engine; otherwise only clear exists.
module board_mem_arbiter
    import tetris_pkg::*;
#(
    parameter int unsigned COLS = BOARD_COLS,
    parameter int unsigned ROWS = BOARD_ROWS,
    parameter int unsigned CW   = CELL_W,
    parameter int unsigned AW   = ADDR_W
) (
    input  logic                clk_25MHz,
    input  logic                reset_n,
    board_mem_arbiter_if.slave  bus,
    input  logic                clear_start,
    input  logic                shift_start,
    input  logic [4:0]          shift_row,
    output logic                eng_busy,
    output logic                eng_done
);

    localparam int unsigned NumCells = ROWS * COLS;
    localparam int unsigned ColW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [AW-1:0]   LastAddr = AW'(NumCells - 1);
    localparam logic [ColW-1:0] LastCol  = ColW'(COLS - 1);

    eng_state_t    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    logic          eng_we;
    logic [AW-1:0] eng_addr;
    logic [CW-1:0] eng_wdata;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [CW-1:0] ram_wdata;
    logic [CW-1:0] ram_rdata;
    logic          addr_ok;

    logic          vid_rd_q, gl_rd_q, oor_q;
    logic          slot_free;

    assign slot_free  = ~bus.vid_req;
    assign eng_busy   = (state_q != StIdle);
    assign eng_done   = (state_q == StDone);
    assign bus.gl_gnt = bus.gl_req & ~bus.vid_req & ~eng_busy;

`ifdef BOARD_ARB_SHIFT_EN
    logic [4:0]      row_q, row_d;
    logic [ColW-1:0] col_q, col_d;
    logic [CW-1:0]   hold_q;
    logic            eng_re, eng_rd_q;
`else
    logic unused_shift;
    assign unused_shift = ^{shift_start, shift_row};
`endif

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        eng_we     = 1'b0;
        eng_addr   = clr_addr_q;
        eng_wdata  = '0;
`ifdef BOARD_ARB_SHIFT_EN
        row_d      = row_q;
        col_d      = col_q;
        eng_re     = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (clear_start) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
`ifdef BOARD_ARB_SHIFT_EN
                else if (shift_start) begin
                    row_d = shift_row;
                    col_d = '0;
                    if (32'(shift_row) >= ROWS) begin
                        state_d = StDone;
                    end else if (shift_row == 5'd0) begin
                        state_d = StShiftTop;
                    end else begin
                        state_d = StShiftRd;
                    end
                end
`endif
            end
            StClear: begin
                if (slot_free) begin
                    eng_we = 1'b1;
                    if (clr_addr_q == LastAddr) begin
                        state_d = StDone;
                    end else begin
                        clr_addr_d = clr_addr_q + AW'(1);
                    end
                end
            end
`ifdef BOARD_ARB_SHIFT_EN
            StShiftRd: begin
                eng_addr = AW'(cell_addr(32'(row_q) - 32'd1, 32'(col_q), COLS));
                if (slot_free) begin
                    eng_re  = 1'b1;
                    state_d = StShiftWr;
                end
            end
            StShiftWr: begin
                eng_addr  = AW'(cell_addr(32'(row_q), 32'(col_q), COLS));
                // Fresh RAM output only in the cycle right after our read; else the held copy.
                eng_wdata = eng_rd_q ? ram_rdata : hold_q;
                if (slot_free) begin
                    eng_we  = 1'b1;
                    state_d = StShiftRd;
                    if (col_q == LastCol) begin
                        col_d = '0;
                        if (row_q == 5'd1) begin
                            state_d = StShiftTop;
                        end else begin
                            row_d = row_q - 5'd1;
                        end
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
            StShiftTop: begin
                eng_addr = AW'(cell_addr(32'd0, 32'(col_q), COLS));
                if (slot_free) begin
                    eng_we = 1'b1;
                    if (col_q == LastCol) begin
                        state_d = StDone;
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = bus.gl_addr;
        ram_wdata = bus.gl_wdata;
        if (bus.vid_req) begin
            ram_addr = bus.vid_addr;
        end else if (eng_busy) begin
            ram_addr  = eng_addr;
            ram_we    = eng_we;
            ram_wdata = eng_wdata;
        end else if (bus.gl_req) begin
            ram_we = bus.gl_we;
        end
    end

    assign addr_ok = (32'(ram_addr) < NumCells);

    board_ram #(
        .Depth (NumCells),
        .AW    (AW),
        .CW    (CW)
    ) u_board_ram (
        .clk_i   (clk_25MHz),
        .we_i    (ram_we & addr_ok),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            clr_addr_q <= '0;
            vid_rd_q   <= 1'b0;
            gl_rd_q    <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            vid_rd_q   <= bus.vid_req;
            gl_rd_q    <= bus.gl_gnt & ~bus.gl_we;
            oor_q      <= ~addr_ok;
        end
    end

`ifdef BOARD_ARB_SHIFT_EN
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            row_q    <= '0;
            col_q    <= '0;
            hold_q   <= '0;
            eng_rd_q <= 1'b0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            eng_rd_q <= eng_re;
            if (eng_rd_q) begin
                hold_q <= ram_rdata;
            end
        end
    end
`endif

    // Read data is masked to 0 for out-of-range reads and outside the owner's data cycle.
    assign bus.vid_rdata = (vid_rd_q & ~oor_q) ? ram_rdata : '0;
    assign bus.gl_rvalid = gl_rd_q;
    assign bus.gl_rdata  = (gl_rd_q & ~oor_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed self-checking bench for board_mem_arbiter; shift checks only when
// BOARD_ARB_SHIFT_EN is defined.
module tb_board_mem_arbiter;
    import tetris_pkg::*;

    logic       clk_25MHz = 1'b0;
    logic       reset_n   = 1'b0;
    logic       clear_start = 1'b0;
    logic       shift_start = 1'b0;
    logic [4:0] shift_row   = 5'd0;
    logic       eng_busy, eng_done;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #20 clk_25MHz = ~clk_25MHz;

    board_mem_arbiter_if #(.AW(8), .CW(3)) bus ();

    board_mem_arbiter #(
        .COLS (10),
        .ROWS (20),
        .CW   (3),
        .AW   (8)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .reset_n     (reset_n),
        .bus         (bus),
        .clear_start (clear_start),
        .shift_start (shift_start),
        .shift_row   (shift_row),
        .eng_busy    (eng_busy),
        .eng_done    (eng_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic gl_write(input logic [7:0] a, input logic [2:0] d);
        bus.gl_req = 1'b1; bus.gl_we = 1'b1; bus.gl_addr = a; bus.gl_wdata = d;
        #1;
        chk("write gnt", 32'(bus.gl_gnt), 1);
        step();
        bus.gl_req = 1'b0; bus.gl_we = 1'b0;
    endtask

    task automatic gl_read(input string tag, input logic [7:0] a, input logic [2:0] exp);
        bus.gl_req = 1'b1; bus.gl_we = 1'b0; bus.gl_addr = a;
        #1;
        chk({tag, " gnt"}, 32'(bus.gl_gnt), 1);
        step();
        bus.gl_req = 1'b0;
        chk({tag, " rvalid"}, 32'(bus.gl_rvalid), 1);
        chk({tag, " rdata"}, 32'(bus.gl_rdata), 32'(exp));
    endtask

    task automatic start_eng(input logic clr, input logic sh, input logic [4:0] row);
        clear_start = clr; shift_start = sh; shift_row = row;
        step();
        clear_start = 1'b0; shift_start = 1'b0;
    endtask

    // Counts busy cycles after a start; optional re-clear pulse and video slot stealing.
    task automatic run_engine(input string tag, input int exp_cycles, input int clr_at,
                              input bit vid_toggle);
        int cnt = 0;
        int dones = 0;
        while (eng_busy === 1'b1 && cnt < 2000) begin
            if (eng_done === 1'b1) dones++;
            clear_start  = (cnt == clr_at);
            bus.vid_req  = vid_toggle & cnt[0];
            bus.vid_addr = 8'd0;
            cnt++;
            step();
        end
        clear_start = 1'b0;
        bus.vid_req = 1'b0;
        chk({tag, " finished"}, 32'(cnt < 2000), 1);
        if (exp_cycles >= 0) chk({tag, " busy cycles"}, 32'(cnt), 32'(exp_cycles));
        chk({tag, " done pulses"}, 32'(dones), 1);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.gl_req = 1'b0; bus.gl_we = 1'b0; bus.gl_addr = '0; bus.gl_wdata = '0;

        // Reset state
        repeat (3) step();
        chk("rst vid_rdata", 32'(bus.vid_rdata), 0);
        chk("rst gl_gnt", 32'(bus.gl_gnt), 0);
        chk("rst gl_rvalid", 32'(bus.gl_rvalid), 0);
        chk("rst gl_rdata", 32'(bus.gl_rdata), 0);
        chk("rst eng_busy", 32'(eng_busy), 0);
        chk("rst eng_done", 32'(eng_done), 0);
        reset_n = 1'b1;
        step();

        // Uncontested clear, then every cell reads back 0
        start_eng(1'b1, 1'b0, 5'd0);
        run_engine("clear", 201, -1, 1'b0);
        for (int a = 0; a < 200; a++) gl_read("clr rd", 8'(a), 3'd0);

        // Game-logic write/read, including out-of-range address
        gl_write(8'd37, 3'd5);
        gl_read("rd37", 8'd37, 3'd5);
        gl_write(8'd210, 3'd6);
        gl_read("rd210", 8'd210, 3'd0);
        gl_write(8'd12, 3'd3);
        gl_write(8'd13, 3'd4);

        // Video holds the port; game logic waits, video data lags address by one cycle
        bus.vid_req = 1'b1; bus.vid_addr = 8'd37;
        bus.gl_req = 1'b1; bus.gl_we = 1'b0; bus.gl_addr = 8'd12;
        #1;
        chk("vid blocks gnt", 32'(bus.gl_gnt), 0);
        step();
        chk("vid rd37", 32'(bus.vid_rdata), 5);
        chk("vid blocks gnt 2", 32'(bus.gl_gnt), 0);
        bus.vid_addr = 8'd12;
        step();
        chk("vid rd12", 32'(bus.vid_rdata), 3);
        bus.vid_addr = 8'd250;
        step();
        chk("vid rd250 oor", 32'(bus.vid_rdata), 0);
        bus.vid_addr = 8'd13;
        step();
        chk("vid rd13", 32'(bus.vid_rdata), 4);
        bus.vid_req = 1'b0;
        #1;
        chk("gnt after vid drop", 32'(bus.gl_gnt), 1);
        step();
        bus.gl_req = 1'b0;
        chk("gl rvalid after wait", 32'(bus.gl_rvalid), 1);
        chk("gl rdata after wait", 32'(bus.gl_rdata), 3);
        chk("vid_rdata idle", 32'(bus.vid_rdata), 0);

        // Clear and shift together: clear wins; a re-clear while busy is ignored
        start_eng(1'b1, 1'b1, 5'd19);
        run_engine("clr+shift", 201, 50, 1'b0);
        gl_read("after clr+shift rd37", 8'd37, 3'd0);

`ifdef BOARD_ARB_SHIFT_EN
        for (int c = 0; c < 10; c++) begin
            gl_write(8'(180 + c), 3'd3);
            gl_write(8'(190 + c), 3'd7);
            gl_write(8'(c), 3'd1);
        end
        gl_write(8'd170, 3'd2);
        start_eng(1'b0, 1'b1, 5'd19);
        run_engine("shift19", 391, -1, 1'b0);
        for (int c = 0; c < 10; c++) gl_read("row19", 8'(190 + c), 3'd3);
        for (int c = 0; c < 10; c++) gl_read("row0", 8'(c), 3'd0);
        gl_read("row18 c0", 8'd180, 3'd2);
        gl_read("row18 c1", 8'd181, 3'd0);
        gl_read("row17 c0", 8'd170, 3'd0);
        gl_read("row1 c0", 8'd10, 3'd1);

        // Same shift with video stealing every other slot
        start_eng(1'b0, 1'b1, 5'd19);
        run_engine("shift19 contested", -1, -1, 1'b1);
        gl_read("c row19 c0", 8'd190, 3'd2);
        gl_read("c row19 c1", 8'd191, 3'd0);
        gl_read("c row2 c0", 8'd20, 3'd1);
        gl_read("c row2 c5", 8'd25, 3'd1);
        gl_read("c row1 c0", 8'd10, 3'd0);
        gl_read("c row0 c0", 8'd0, 3'd0);

        // Boundary rows
        start_eng(1'b0, 1'b1, 5'd0);
        run_engine("shift0", 11, -1, 1'b0);
        start_eng(1'b0, 1'b1, 5'd25);
        run_engine("shift25", 1, -1, 1'b0);
        gl_read("after shift25 rd190", 8'd190, 3'd2);
`else
        gl_write(8'd190, 3'd2);
        start_eng(1'b0, 1'b1, 5'd19);
        chk("shift ignored busy", 32'(eng_busy), 0);
        chk("shift ignored done", 32'(eng_done), 0);
        gl_read("shift ignored rd190", 8'd190, 3'd2);
`endif

        // Reset mid-clear: async output clear, no done pulse, partial board kept
        gl_write(8'd3, 3'd7);
        gl_write(8'd150, 3'd6);
        start_eng(1'b1, 1'b0, 5'd0);
        dones = 0;
        for (int i = 0; i < 29; i++) begin
            if (eng_done === 1'b1) dones++;
            step();
        end
        bus.vid_req = 1'b1; bus.vid_addr = 8'd150;
        step();
        chk("pre-reset vid rd150", 32'(bus.vid_rdata), 6);
        chk("pre-reset busy", 32'(eng_busy), 1);
        reset_n = 1'b0;
        #1;
        chk("async rst busy", 32'(eng_busy), 0);
        chk("async rst done", 32'(eng_done), 0);
        chk("async rst vid_rdata", 32'(bus.vid_rdata), 0);
        chk("async rst rvalid", 32'(bus.gl_rvalid), 0);
        chk("async rst rdata", 32'(bus.gl_rdata), 0);
        chk("async rst gnt", 32'(bus.gl_gnt), 0);
        bus.vid_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (eng_done === 1'b1) dones++;
            step();
        end
        reset_n = 1'b1;
        step();
        if (eng_done === 1'b1) dones++;
        chk("mid-clear reset no done", 32'(dones), 0);
        chk("post-reset idle", 32'(eng_busy), 0);
        gl_read("partial clear rd3", 8'd3, 3'd0);
        gl_read("partial clear rd150", 8'd150, 3'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Owns the playfield board memory and shares its single port among three requesters: the HDMI pixel renderer (read-only, never stalled), the game logic (read/write with grant), and an internal maintenance engine that clears the board and shifts rows down after a line clear. Sits in the 25 MHz pixel domain between game_logic and the renderer, replacing direct board-register access by both. The board is ROWS x COLS cells, each holding a color code: 0 = empty, 1..7 = tetromino type.

## Interface
- COLS, 10, board width in cells
- ROWS, 20, board height in cells
- CW, 3, cell color width
- AW, 8, address width; addr = row*COLS + col, valid range 0..ROWS*COLS-1
- clk_25MHz  in  1  pixel/system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  renderer read request
- vid_addr  in  AW  renderer cell address
- vid_rdata  out  CW  renderer read data
- gl_req  in  1  game-logic access request
- gl_we  in  1  1 = write, 0 = read
- gl_addr  in  AW  game-logic cell address
- gl_wdata  in  CW  game-logic write data
- gl_gnt  out  1  game-logic request accepted this cycle
- gl_rvalid  out  1  game-logic read data valid
- gl_rdata  out  CW  game-logic read data
- clear_start  in  1  pulse: start full-board clear
- shift_start  in  1  pulse: start row-shift of shift_row
- shift_row  in  5  row index to remove (0 = top)
- eng_busy  out  1  maintenance engine active
- eng_done  out  1  one-cycle pulse on engine completion

## Operation
- Single-port RAM, one access per cycle, 1-cycle read latency.
- Fixed priority per cycle: vid_req > engine > game logic.
- Video: always served; no grant signal.
- Game logic: gl_gnt = gl_req & ~vid_req & ~eng_busy (combinational); accepted write commits at that edge; accepted read returns gl_rvalid/gl_rdata next cycle.
- Out-of-range address (>= ROWS*COLS): write discarded, read returns 0; gl_gnt and gl_rvalid still behave normally.
- Engine FSM: IDLE, CLEAR, SHIFT_RD, SHIFT_WR, SHIFT_TOP, DONE.
  - IDLE: clear_start -> CLEAR (eng_busy=1 next cycle). Otherwise shift_start -> SHIFT_RD, with dest row d = shift_row. clear_start wins if both are asserted together; the shift request is dropped.
  - CLEAR: writes 0 to address 0..ROWS*COLS-1 ascending, one per free slot; after the last address -> DONE.
  - SHIFT_RD/SHIFT_WR: for d = shift_row down to 1, col 0..COLS-1: read cell (d-1,col), then write it to (d,col). Each step consumes one free slot. The read data is held in a register across video-stolen slots.
  - SHIFT_TOP: writes 0 to row 0, cols 0..COLS-1; -> DONE.
  - shift_row = 0: go straight to SHIFT_TOP. shift_row >= ROWS: go directly to DONE with no writes.
  - DONE: eng_done=1 for one cycle -> IDLE.
- Engine steps advance only in cycles with vid_req=0.
- Start pulses while eng_busy=1 are ignored.

## Timing
- Reset values: vid_rdata=0, gl_gnt=0, gl_rvalid=0, gl_rdata=0, eng_busy=0, eng_done=0, FSM=IDLE. RAM contents are not reset; the system issues clear_start after reset.
- vid_rdata is valid exactly 1 cycle after vid_req.
- Uncontested clear: eng_busy high for ROWS*COLS+1 cycles (200 writes + DONE).
- Uncontested shift of row r: 2*r*COLS + COLS + 1 cycles.
- Reset asserted mid-operation: engine aborts immediately and eng_done is not pulsed. Board content is whatever was written so far.
- A read and a write to the same address in consecutive cycles: the read returns the new data (write commits before the next access).

## Configuration
- BOARD_ARB_SHIFT_EN defined: row-shift engine present (SHIFT_* states).
- BOARD_ARB_SHIFT_EN undefined: shift_start and shift_row are ignored, and only CLEAR is supported. The ports remain present so top-level wiring is identical.

## Structure
- tetris_pkg holds:
  - BOARD_COLS, BOARD_ROWS, CELL_W
  - typedef cell_t (logic [CELL_W-1:0]) plus the color constants
  - the engine state enum eng_state_t
- Sub-module board_ram: synchronous single-port RAM, ROWS*COLS x CW, with registered read and write-enable. It infers BRAM or distributed RAM and has no reset.

## Test plan
- Reset, then clear_start with vid_req=0: eng_busy high for 201 cycles, eng_done pulses once, and a read of every address returns 0.
- Game-logic write of 5 to address 37, then read 37: gl_gnt=1 each cycle, gl_rvalid one cycle after the read, gl_rdata=5. A write to address 210 is discarded and a read of 210 returns 0.
- vid_req held high while gl_req=1: gl_gnt stays 0 until vid_req drops, then is granted in the same cycle; vid_rdata tracks vid_addr with 1-cycle lag.
- Fill row 18 with 3 and row 19 with 7, then shift_row=19: row 19 reads 3, row 0 reads 0, and completion takes 391 cycles uncontested.
- clear_start and shift_start asserted together: only the clear runs. A second clear_start while busy is ignored and yields exactly one eng_done.
- reset_n pulled low mid-clear: all outputs return to 0 asynchronously, no eng_done is pulsed, and the FSM is in IDLE after release.
